uart_hamming_transmitter: RTL

Serial transmitter for the UART link; the transmit-side peer of the 7-bit Hamming(7,4) UART receiver.
- Accepts a 4-bit nibble (or a raw 7-bit word) through a valid/ready handshake.
- Encodes it to a Hamming(7,4) codeword and shifts out one frame: start bit, 7 data bits LSB first, stop bit(s), at CLKS_PER_BIT clocks per bit.
- Sits between the tile's user-input logic and the tx pad.

---
 rtl/uart_pkg.sv | 16 +
 rtl/hamming74_encoder.sv | 18 +
 rtl/uart_hamming_transmitter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the Hamming(7,4) UART transmitter and its receive-side peer.
package uart_pkg;

    // Same 2-bit encoding as the receiver.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int HAMMING_N            = 7;
    localparam int HAMMING_K            = 4;
    localparam int CLKS_PER_BIT_DEFAULT = 8;

endpackage

// File: rtl/hamming74_encoder.sv
// Combinational Hamming(7,4) encoder; code[0] is the first bit on the wire.
module hamming74_encoder
    import uart_pkg::*;
(
    input  logic [HAMMING_K-1:0] i_data,
    output logic [HAMMING_N-1:0] o_code
);

    logic w_p1, w_p2, w_p3;

    assign w_p1 = i_data[0] ^ i_data[1] ^ i_data[3];
    assign w_p2 = i_data[0] ^ i_data[2] ^ i_data[3];
    assign w_p3 = i_data[1] ^ i_data[2] ^ i_data[3];

    // Classic position order 7..1; the decoder relies on this exact mapping.
    assign o_code = {i_data[3], i_data[2], i_data[1], w_p3, i_data[0], w_p2, w_p1};

endmodule

// File: rtl/uart_hamming_transmitter.sv
// UART frame transmitter: start bit, 7 code bits LSB first, stop bit(s).
// Payload is Hamming(7,4) encoded unless ENCODE=0, in which case 7 raw bits are sent.
module uart_hamming_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int STOP_BITS    = 1,
    parameter int ENCODE       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [6:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int             CW            = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CLK_LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CLK_STOP_LAST = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]     BIT_LAST      = 3'(HAMMING_N - 1);
    localparam logic [2:0]     STOP_LAST     = 3'(STOP_BITS - 1);

    uart_state_e            r_state, w_state_next;
    logic [CW-1:0]          r_clk_cnt, w_clk_cnt_next;
    logic [2:0]             r_bit_cnt, w_bit_cnt_next;
    logic [HAMMING_N-1:0]   r_shift, w_shift_next;
    logic                   r_tx, w_tx_next;
    logic                   r_done, w_done_next;
    logic [HAMMING_N-1:0]   w_code, w_payload;
    logic                   w_clk_last, w_transfer;

    hamming74_encoder u_encoder (
        .i_data (data_in[HAMMING_K-1:0]),
        .o_code (w_code)
    );

    assign w_payload  = (ENCODE != 0) ? w_code : data_in;
    assign w_transfer = valid_in && (r_state == IDLE);
    assign w_clk_last = (r_clk_cnt == CLK_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_done_next    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_transfer) begin
                    w_state_next   = START;
                    w_shift_next   = w_payload;
                    w_clk_cnt_next = '0;
                    w_bit_cnt_next = '0;
                end
            end
            START: begin
                if (w_clk_last) begin
                    w_state_next   = DATA;
                    w_clk_cnt_next = '0;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (w_clk_last) begin
                    w_clk_cnt_next = '0;
                    w_shift_next   = r_shift >> 1;
                    if (r_bit_cnt == BIT_LAST) begin
                        w_state_next   = STOP;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            STOP: begin
                // The done cycle in IDLE is itself the last stop-bit clock, so leave one early.
                if ((r_bit_cnt == STOP_LAST) && (r_clk_cnt == CLK_STOP_LAST)) begin
                    w_state_next   = IDLE;
                    w_clk_cnt_next = '0;
                    w_bit_cnt_next = '0;
                    w_done_next    = 1'b1;
                end else if (w_clk_last) begin
                    w_clk_cnt_next = '0;
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_clk_cnt_next = '0;
                w_bit_cnt_next = '0;
            end
        endcase

        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else if (ena) begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            r_done    <= w_done_next;
        end
    end

    assign ready_out = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign tx        = r_tx;
    assign done      = r_done;

endmodule
